// File: rtl/otter_pkg.sv
// Shared types for the OTTER store path: RS tag type, memory size codes,
// store-buffer entry layout and drain FSM state encoding.
package otter_pkg;

    localparam int XLEN     = 32;
    localparam int RS_TAG_W = 4;

    typedef logic [RS_TAG_W-1:0] RS_tag_type;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [1:0]      size;
        RS_tag_type      tag;
    } sb_entry_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_WRITE
    } drain_state_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular in-order FIFO of store-buffer entries.
// With STORE_FWD_EN defined, the raw entry array and head pointer are
// exported so the parent can search pending stores for load forwarding.
module store_buffer_fifo
    import otter_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             push,
    input  sb_entry_t                        push_entry,
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(SB_DEPTH+1)-1:0]    count,
    output sb_entry_t                        head
`ifdef STORE_FWD_EN
    ,
    output sb_entry_t [SB_DEPTH-1:0]         entries,
    output logic [$clog2(SB_DEPTH)-1:0]      head_ptr
`endif
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH+1);

    sb_entry_t [SB_DEPTH-1:0] mem;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push_ok;
    logic                     pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    assign full  = (count == CNT_W'(SB_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

`ifdef STORE_FWD_EN
    assign entries  = mem;
    assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts stores from the RS, computes the effective address,
// queues them in order, drains them to memory port 2 and broadcasts the
// store tag on the CDB. Define STORE_FWD_EN to add store-to-load forwarding.
//
// state       | meaning
// DRAIN_IDLE  | buffer empty (or just filled), no write request
// DRAIN_WRITE | head entry presented on port 2, waiting for mem_ack
module store_unit
    import otter_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           issue_valid,
    input  logic [ADDR_W-1:0]              V1,
    input  logic [ADDR_W-1:0]              V2,
    input  logic [ADDR_W-1:0]              V3,
    input  logic                           V1_valid,
    input  logic                           V2_valid,
    input  logic                           V3_valid,
    input  RS_tag_type                     st_tag,
    input  logic [2:0]                     mem_type,
    output logic                           issue_ready,
    input  logic                           CDB_busy,
    output logic                           CDB_req,
    output logic [ADDR_W-1:0]              CDB_val,
    output RS_tag_type                     CDB_tag,
    output logic                           MEM_WE2,
    output logic [ADDR_W-1:0]              MEM_ADDR2,
    output logic [ADDR_W-1:0]              MEM_DIN2,
    output logic [1:0]                     MEM_SIZE,
    input  logic                           mem_ack,
    output logic                           sb_empty,
    output logic [$clog2(SB_DEPTH+1)-1:0]  sb_count
`ifdef STORE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]              ld_addr,
    input  logic [1:0]                     ld_size,
    output logic                           fwd_hit,
    output logic [ADDR_W-1:0]              fwd_data
`endif
);

    localparam int CNT_W = $clog2(SB_DEPTH+1);

    drain_state_t drain_state;
    logic         mem_we;
    logic         out_of_reset;
    logic         bcast_pending;
    RS_tag_type   bcast_tag;
    logic         sb_full;
    logic         accept;
    logic         pop;
    sb_entry_t    push_entry;
    sb_entry_t    head;
    logic         unused_bits;

`ifdef STORE_FWD_EN
    localparam int PTR_W = $clog2(SB_DEPTH);
    sb_entry_t [SB_DEPTH-1:0] entries;
    logic [PTR_W-1:0]         head_ptr;
    logic [PTR_W-1:0]         fwd_idx;
    logic                     unused_fwd;
`endif

    // Ready depends only on registers so it never combinationally follows a pop.
    assign issue_ready = out_of_reset && !sb_full && !bcast_pending;
    assign accept      = issue_valid && issue_ready && V1_valid && V2_valid && V3_valid;
    assign pop         = mem_we && mem_ack;

    assign push_entry.addr = V1 + V2;
    assign push_entry.data = V3;
    assign push_entry.size = mem_type[1:0];
    assign push_entry.tag  = st_tag;

    store_buffer_fifo #(.SB_DEPTH(SB_DEPTH)) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (sb_full),
        .empty      (sb_empty),
        .count      (sb_count),
        .head       (head)
`ifdef STORE_FWD_EN
        ,
        .entries    (entries),
        .head_ptr   (head_ptr)
`endif
    );

    // Holds ready low for the reset period; rises on the first edge after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) out_of_reset <= 1'b0;
        else        out_of_reset <= 1'b1;
    end

    // Broadcast slot: loaded on acceptance, cleared once the CDB is won.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bcast_pending <= 1'b0;
            bcast_tag     <= '0;
        end else if (accept) begin
            bcast_pending <= 1'b1;
            bcast_tag     <= st_tag;
        end else if (CDB_req) begin
            bcast_pending <= 1'b0;
        end
    end

    assign CDB_req = bcast_pending && !CDB_busy;
    assign CDB_tag = CDB_req ? bcast_tag : '0;
    assign CDB_val = '0;

    // Drain FSM; stays in WRITE across pops while the buffer still holds entries.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drain_state <= DRAIN_IDLE;
            mem_we      <= 1'b0;
        end else begin
            case (drain_state)
                DRAIN_IDLE: begin
                    if (!sb_empty) begin
                        drain_state <= DRAIN_WRITE;
                        mem_we      <= 1'b1;
                    end
                end
                DRAIN_WRITE: begin
                    if (mem_ack && sb_count == CNT_W'(1) && !accept) begin
                        drain_state <= DRAIN_IDLE;
                        mem_we      <= 1'b0;
                    end
                end
                default: begin
                    drain_state <= DRAIN_IDLE;
                    mem_we      <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_WE2   = mem_we;
    assign MEM_ADDR2 = mem_we ? head.addr : '0;
    assign MEM_DIN2  = mem_we ? head.data : '0;
    assign MEM_SIZE  = mem_we ? head.size : '0;

    assign unused_bits = ^{mem_type[2], head.tag};

`ifdef STORE_FWD_EN
    // Walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit    = 1'b0;
        fwd_data   = '0;
        fwd_idx    = '0;
        unused_fwd = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            unused_fwd = unused_fwd ^ (^entries[i].tag);
            fwd_idx    = head_ptr + PTR_W'(i);
            if (CNT_W'(i) < sb_count &&
                entries[fwd_idx].addr == ld_addr &&
                entries[fwd_idx].size == ld_size) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwd_idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_unit.sv
`timescale 1ns/1ps
module tb_store_unit;
    import otter_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             issue_valid;
    logic [31:0]      V1, V2, V3;
    logic             V1_valid, V2_valid, V3_valid;
    RS_tag_type       st_tag;
    logic [2:0]       mem_type;
    logic             issue_ready;
    logic             CDB_busy;
    logic             CDB_req;
    logic [31:0]      CDB_val;
    RS_tag_type       CDB_tag;
    logic             MEM_WE2;
    logic [31:0]      MEM_ADDR2, MEM_DIN2;
    logic [1:0]       MEM_SIZE;
    logic             mem_ack;
    logic             sb_empty;
    logic [CW-1:0]    sb_count;
`ifdef STORE_FWD_EN
    logic [31:0]      ld_addr;
    logic [1:0]       ld_size;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
`endif

    always #5 CLK = ~CLK;

    store_unit #(.SB_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .issue_valid (issue_valid),
        .V1          (V1),
        .V2          (V2),
        .V3          (V3),
        .V1_valid    (V1_valid),
        .V2_valid    (V2_valid),
        .V3_valid    (V3_valid),
        .st_tag      (st_tag),
        .mem_type    (mem_type),
        .issue_ready (issue_ready),
        .CDB_busy    (CDB_busy),
        .CDB_req     (CDB_req),
        .CDB_val     (CDB_val),
        .CDB_tag     (CDB_tag),
        .MEM_WE2     (MEM_WE2),
        .MEM_ADDR2   (MEM_ADDR2),
        .MEM_DIN2    (MEM_DIN2),
        .MEM_SIZE    (MEM_SIZE),
        .mem_ack     (mem_ack),
        .sb_empty    (sb_empty),
        .sb_count    (sb_count)
`ifdef STORE_FWD_EN
        ,
        .ld_addr     (ld_addr),
        .ld_size     (ld_size),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    // Reference model: a queue of pending stores in acceptance order.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ref_t;

    ref_t        sbq[$];
    logic [31:0] wr_log[$];
    logic [31:0] acc_log[$];
    bit          pend;
    RS_tag_type  pend_tag;
    bit          alive;
    int          prev_size;
    int          n_acc;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    // at the rising edge. Inputs are driven by the caller after a falling edge.
    task automatic run_cycle();
        bit   exp_ready, accept, bcast, exp_we, popq;
        int   sz;
        ref_t e;
`ifdef STORE_FWD_EN
        bit          hit;
        logic [31:0] fd;
`endif
        #1;
        sz        = sbq.size();
        exp_ready = alive && (sz < DEPTH) && !pend;
        chk("issue_ready", issue_ready, exp_ready);
        chk("sb_count", sb_count, sz);
        chk("sb_empty", sb_empty, sz == 0);
        accept = exp_ready && issue_valid && V1_valid && V2_valid && V3_valid;
        bcast  = pend && !CDB_busy;
        chk("cdb_req", CDB_req, bcast);
        if (bcast) chk("cdb_tag", CDB_tag, pend_tag);
        chk("cdb_val", CDB_val, 0);
        // A non-empty buffer is presented from the cycle after it first holds data
        // and stays presented while data remains.
        exp_we = (prev_size > 0) && (sz > 0);
        chk("mem_we2", MEM_WE2, exp_we);
        popq = exp_we && mem_ack;
        if (exp_we) begin
            chk("mem_addr2", MEM_ADDR2, sbq[0].addr);
            chk("mem_din2", MEM_DIN2, sbq[0].data);
            chk("mem_size", MEM_SIZE, sbq[0].size);
        end
`ifdef STORE_FWD_EN
        hit = 0;
        fd  = '0;
        foreach (sbq[i]) begin
            if (sbq[i].addr == ld_addr && sbq[i].size == ld_size) begin
                hit = 1;
                fd  = sbq[i].data;
            end
        end
        chk("fwd_hit", fwd_hit, hit);
        if (hit) chk("fwd_data", fwd_data, fd);
`endif
        @(posedge CLK);
        prev_size = sz;
        if (popq) begin
            wr_log.push_back(sbq[0].addr);
            void'(sbq.pop_front());
        end
        if (bcast) pend = 0;
        if (accept) begin
            e.addr = V1 + V2;
            e.data = V3;
            e.size = mem_type[1:0];
            sbq.push_back(e);
            acc_log.push_back(e.addr);
            pend     = 1;
            pend_tag = st_tag;
            n_acc++;
        end
        if (RST_N) alive = 1;
        @(negedge CLK);
    endtask

    task automatic try_issue(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                             input logic [1:0] sz, input RS_tag_type tag);
        int start;
        start       = n_acc;
        issue_valid = 1'b1;
        V1 = v1; V2 = v2; V3 = v3;
        V1_valid = 1'b1; V2_valid = 1'b1; V3_valid = 1'b1;
        mem_type = {1'b0, sz};
        st_tag   = tag;
        for (int i = 0; i < 20 && n_acc == start; i++) run_cycle();
        issue_valid = 1'b0;
        chk("issue_accepted", n_acc - start, 1);
    endtask

    task automatic drain(input int bound);
        mem_ack = 1'b1;
        for (int i = 0; i < bound && sbq.size() > 0; i++) run_cycle();
        run_cycle();
        chk("drain_done", sb_empty, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; n_acc = 0;
        pend = 0; alive = 0; prev_size = 0; pend_tag = '0;
        issue_valid = 0; V1 = 0; V2 = 0; V3 = 0;
        V1_valid = 0; V2_valid = 0; V3_valid = 0;
        st_tag = '0; mem_type = '0; CDB_busy = 0; mem_ack = 0;
`ifdef STORE_FWD_EN
        ld_addr = '0; ld_size = '0;
`endif
        #2;
        chk("rst_we", MEM_WE2, 0);
        chk("rst_req", CDB_req, 0);
        chk("rst_tag", CDB_tag, 0);
        chk("rst_val", CDB_val, 0);
        chk("rst_addr", MEM_ADDR2, 0);
        chk("rst_din", MEM_DIN2, 0);
        chk("rst_size", MEM_SIZE, 0);
        chk("rst_empty", sb_empty, 1);
        chk("rst_count", sb_count, 0);
        chk("rst_ready", issue_ready, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_cycle();
        chk("ready_after_rst", issue_ready, 1);

        // Single store
        wr_log.delete();
        mem_ack = 1'b1;
        try_issue(32'h1000, 32'h4, 32'hDEADBEEF, MEM_WORD, 4'd3);
        chk("t1_cdb_req", CDB_req, 1);
        chk("t1_cdb_tag", CDB_tag, 3);
        drain(10);
        chk("t1_nwrites", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("t1_addr", wr_log[0], 32'h1004);

        // CDB contention
        CDB_busy = 1'b1;
        mem_ack  = 1'b0;
        try_issue(32'h50, 32'h0, 32'h1234, MEM_HALF, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_req_held", CDB_req, 0);
            chk("t2_ready_held", issue_ready, 0);
            if (i == 2) CDB_busy = 1'b0;
            else run_cycle();
        end
        #1;
        chk("t2_req_free", CDB_req, 1);
        chk("t2_tag_free", CDB_tag, 5);
        run_cycle();
        drain(10);

        // Fill with mem_ack low, then drain at one per cycle
        mem_ack = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            try_issue(32'h3000 + 32'(k * 16), 32'h0, 32'hA0 + 32'(k), MEM_BYTE, RS_tag_type'(k + 8));
        run_cycle();
        run_cycle();
        chk("t3_full_count", sb_count, DEPTH);
        chk("t3_full_ready", issue_ready, 0);
        wr_log.delete();
        mem_ack = 1'b1;
        for (int k = 0; k < DEPTH; k++) run_cycle();
        chk("t3_nwrites", wr_log.size(), DEPTH);
        foreach (wr_log[k]) chk("t3_order", wr_log[k], 32'h3000 + 32'(k * 16));
        drain(5);

        // Address wrap and order through pointer wrap-around
        wr_log.delete();
        try_issue(32'hFFFFFFFC, 32'h8, 32'h77, MEM_WORD, 4'd1);
        drain(10);
        chk("t4_wrap_addr", wr_log.size() > 0 ? wr_log[0] : 32'hX, 32'h4);
        wr_log.delete();
        acc_log.delete();
        for (int k = 0; k < 10; k++) begin
            mem_ack = 1'($urandom_range(0, 1));
            try_issue($urandom, $urandom, $urandom, 2'($urandom_range(0, 2)), RS_tag_type'(k));
        end
        drain(30);
        chk("t4_nwrites", wr_log.size(), 10);
        foreach (acc_log[k]) if (k < wr_log.size()) chk("t4_order", wr_log[k], acc_log[k]);

        // Reset during a pending write with broadcast still pending
        CDB_busy = 1'b1;
        mem_ack  = 1'b0;
        try_issue(32'h4000, 32'h0, 32'hCAFE, MEM_WORD, 4'd7);
        for (int i = 0; i < 10 && !MEM_WE2; i++) run_cycle();
        chk("t5_we_before", MEM_WE2, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t5_we_async", MEM_WE2, 0);
        chk("t5_count_async", sb_count, 0);
        chk("t5_req_async", CDB_req, 0);
        chk("t5_ready_async", issue_ready, 0);
        sbq.delete();
        pend = 0; alive = 0; prev_size = 0;
        @(negedge CLK);
        RST_N    = 1'b1;
        CDB_busy = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        chk("t5_count_after", sb_count, 0);

`ifdef STORE_FWD_EN
        // Forwarding picks the youngest matching pending store
        mem_ack = 1'b0;
        ld_addr = 32'h2000;
        ld_size = MEM_WORD;
        try_issue(32'h2000, 32'h0, 32'h11, MEM_WORD, 4'd2);
        try_issue(32'h1FF0, 32'h10, 32'h22, MEM_WORD, 4'd4);
        run_cycle();
        #1;
        chk("t6_fwd_hit", fwd_hit, 1);
        chk("t6_fwd_data", fwd_data, 32'h22);
        ld_size = MEM_HALF;
        #1;
        chk("t6_fwd_size_miss", fwd_hit, 0);
        @(negedge CLK);
        drain(10);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            V1_valid    = ($urandom_range(0, 9) < 8);
            V2_valid    = ($urandom_range(0, 9) < 8);
            V3_valid    = ($urandom_range(0, 9) < 8);
            V1          = $urandom;
            V2          = (c % 3 == 0) ? 32'h0 : $urandom;
            V3          = $urandom;
            mem_type    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            st_tag      = RS_tag_type'($urandom);
            CDB_busy    = ($urandom_range(0, 9) < 3);
            mem_ack     = 1'($urandom_range(0, 1));
`ifdef STORE_FWD_EN
            if (sbq.size() > 0 && $urandom_range(0, 1) == 1) begin
                int j;
                j       = $urandom_range(0, sbq.size() - 1);
                ld_addr = sbq[j].addr;
                ld_size = sbq[j].size;
            end else begin
                ld_addr = $urandom;
                ld_size = 2'($urandom_range(0, 2));
            end
`endif
            run_cycle();
        end
        issue_valid = 1'b0;
        CDB_busy    = 1'b0;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
